// File: rtl/blink_bus_master.sv
// Host-command bus initiator for the blink LED register port.
// Every write is read back and compared; broadcast covers all four registers.
module blink_bus_master #(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic             cmd_bcast,
    input  logic [1:0]       cmd_addr,
    input  logic [15:0]      cmd_data,
    output logic             resp_valid,
    output logic [15:0]      resp_data,
    output logic             resp_err,
    output logic [ERR_W-1:0] err_count,
    output logic             cs,
    output logic             we,
    output logic             rd,
    output logic [1:0]       addr,
    output logic [15:0]      wr_data,
    input  logic [15:0]      rd_data
);

    typedef enum logic [2:0] {IDLE, WRITE, VERIFY, READ, RESP} state_t;

    state_t           state_q;
    logic             bcast_q;
    logic [15:0]      data_q;
    logic [1:0]       beat_q;
    logic             flag_q;
    logic             cmd_ready_q;
    logic             resp_valid_q;
    logic             resp_err_q;
    logic [15:0]      resp_data_q;
    logic [ERR_W-1:0] err_q;
    logic             cs_q;
    logic             we_q;
    logic             rd_q;
    logic [1:0]       addr_q;
    logic [15:0]      wr_data_q;

    logic             mism_d;
    logic             last_d;
    logic [1:0]       beat_d;
    logic [ERR_W-1:0] err_d;

    always_comb begin
        mism_d = (rd_data != data_q);
        last_d = !bcast_q || (beat_q == 2'd3);
        beat_d = beat_q + 2'd1;
        err_d  = err_q;
        if (state_q == VERIFY && mism_d && !(&err_q))
            err_d = err_q + ERR_W'(1);
    end

    // Bus strobes are registered from the next state so they line up
    // with the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            bcast_q      <= 1'b0;
            data_q       <= '0;
            beat_q       <= '0;
            flag_q       <= 1'b0;
            cmd_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= '0;
            err_q        <= '0;
            cs_q         <= 1'b0;
            we_q         <= 1'b0;
            rd_q         <= 1'b0;
            addr_q       <= '0;
            wr_data_q    <= '0;
        end else begin
            cmd_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            cs_q         <= 1'b0;
            we_q         <= 1'b0;
            rd_q         <= 1'b0;
            addr_q       <= '0;
            wr_data_q    <= '0;
            err_q        <= err_d;
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        bcast_q <= cmd_bcast;
                        data_q  <= cmd_data;
                        beat_q  <= cmd_bcast ? 2'd0 : cmd_addr;
                        cs_q    <= 1'b1;
                        if (cmd_we) begin
                            state_q   <= WRITE;
                            we_q      <= 1'b1;
                            addr_q    <= cmd_bcast ? 2'd0 : cmd_addr;
                            wr_data_q <= cmd_data;
                        end else begin
                            state_q <= READ;
                            rd_q    <= 1'b1;
                            addr_q  <= cmd_addr;
                        end
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                WRITE: begin
                    state_q <= VERIFY;
                    cs_q    <= 1'b1;
                    rd_q    <= 1'b1;
                    addr_q  <= beat_q;
                end
                VERIFY: begin
                    resp_data_q <= rd_data;
                    if (last_d) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= flag_q | mism_d;
                        flag_q       <= 1'b0;
                    end else begin
                        state_q   <= WRITE;
                        beat_q    <= beat_d;
                        flag_q    <= flag_q | mism_d;
                        cs_q      <= 1'b1;
                        we_q      <= 1'b1;
                        addr_q    <= beat_d;
                        wr_data_q <= data_q;
                    end
                end
                READ: begin
                    state_q      <= RESP;
                    resp_data_q  <= rd_data;
                    resp_valid_q <= 1'b1;
                end
                RESP: begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign err_count  = err_q;
    assign cs         = cs_q;
    assign we         = we_q;
    assign rd         = rd_q;
    assign addr       = addr_q;
    assign wr_data    = wr_data_q;

endmodule

// File: tb/tb_blink_bus_master.sv
// Directed bench for blink_bus_master with a small register-file
// peripheral model that can hold address 2 stuck at zero.
module tb_blink_bus_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic        cmd_bcast = 1'b0;
    logic [1:0]  cmd_addr = 2'd0;
    logic [15:0] cmd_data = 16'h0;
    logic        resp_valid;
    logic [15:0] resp_data;
    logic        resp_err;
    logic [7:0]  err_count;
    logic        cs, we, rd;
    logic [1:0]  addr;
    logic [15:0] wr_data;
    logic [15:0] rd_data;

    logic        mdl_clr = 1'b1;
    logic        stuck2 = 1'b0;
    logic [15:0] regs [4];

    int pass_cnt = 0;
    int total_cnt = 0;

    blink_bus_master #(.ERR_W(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_we(cmd_we), .cmd_bcast(cmd_bcast),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_err(resp_err), .err_count(err_count),
        .cs(cs), .we(we), .rd(rd), .addr(addr),
        .wr_data(wr_data), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mdl_clr) begin
            for (int i = 0; i < 4; i++) regs[i] <= 16'h0;
        end else if (cs && we) begin
            regs[addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data = 16'h0;
        if (cs && rd)
            rd_data = (stuck2 && addr == 2'd2) ? 16'h0 : regs[addr];
    end

    task automatic test_reset();
        rst = 1'b1;
        mdl_clr = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mdl_clr = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({cs, we, rd, addr, wr_data} !== 21'h0)
            $display("FAIL rst_bus: got %b%b%b a=%h d=%h exp all 0", cs, we, rd, addr, wr_data);
        else pass_cnt++;
        total_cnt++;
        if ({cmd_ready, resp_valid, resp_err} !== 3'b100)
            $display("FAIL rst_ctl: got rdy/rv/re=%b%b%b exp 100", cmd_ready, resp_valid, resp_err);
        else pass_cnt++;
        total_cnt++;
        if ({resp_data, err_count} !== 24'h0)
            $display("FAIL rst_data: got rdata=%h err=%0d exp 0/0", resp_data, err_count);
        else pass_cnt++;
    endtask

    task automatic test_read();
        cmd_we = 1'b0; cmd_bcast = 1'b0; cmd_addr = 2'd2; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        total_cnt++;
        if ({cs, we, rd, addr, resp_valid} !== 6'b101100)
            $display("FAIL read_bus: got cs/we/rd=%b%b%b a=%h rv=%b exp 101 a=2 rv=0", cs, we, rd, addr, resp_valid);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({resp_valid, resp_err, resp_data, we} !== {2'b10, 16'h0, 1'b0})
            $display("FAIL read_resp: got rv=%b re=%b d=%h we=%b exp 1 0 0000 0", resp_valid, resp_err, resp_data, we);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({cmd_ready, resp_valid} !== 2'b10)
            $display("FAIL read_idle: got rdy=%b rv=%b exp 1 0", cmd_ready, resp_valid);
        else pass_cnt++;
    endtask

    task automatic test_write();
        cmd_we = 1'b1; cmd_bcast = 1'b0; cmd_addr = 2'd1; cmd_data = 16'h1234; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        total_cnt++;
        if ({cs, we, rd, addr, wr_data} !== {3'b110, 2'd1, 16'h1234})
            $display("FAIL wr_we: got %b%b%b a=%h d=%h exp 110 a=1 d=1234", cs, we, rd, addr, wr_data);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({cs, we, rd, addr, wr_data} !== {3'b101, 2'd1, 16'h0})
            $display("FAIL wr_rd: got %b%b%b a=%h d=%h exp 101 a=1 d=0", cs, we, rd, addr, wr_data);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({resp_valid, resp_err, resp_data, err_count, cmd_ready} !== {2'b10, 16'h1234, 8'd0, 1'b0})
            $display("FAIL wr_resp: got rv=%b re=%b d=%h err=%0d rdy=%b exp 1 0 1234 0 0",
                     resp_valid, resp_err, resp_data, err_count, cmd_ready);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({cmd_ready, resp_valid} !== 2'b10)
            $display("FAIL wr_idle: got rdy=%b rv=%b exp 1 0", cmd_ready, resp_valid);
        else pass_cnt++;
    endtask

    task automatic test_bcast();
        cmd_we = 1'b1; cmd_bcast = 1'b1; cmd_addr = 2'd2; cmd_data = 16'hBEEF; cmd_valid = 1'b1;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            total_cnt++;
            if ({cs, we, rd, addr, wr_data} !== {3'b110, 2'(b), 16'hBEEF})
                $display("FAIL bc_w%0d: got %b%b%b a=%h d=%h exp 110 a=%0d d=beef", b, cs, we, rd, addr, wr_data, b);
            else pass_cnt++;
            @(negedge clk);
            total_cnt++;
            if ({cs, we, rd, addr, resp_valid} !== {3'b101, 2'(b), 1'b0})
                $display("FAIL bc_v%0d: got %b%b%b a=%h rv=%b exp 101 a=%0d rv=0", b, cs, we, rd, addr, resp_valid, b);
            else pass_cnt++;
        end
        @(negedge clk);
        total_cnt++;
        if ({resp_valid, resp_err, resp_data} !== {2'b10, 16'hBEEF})
            $display("FAIL bc_resp: got rv=%b re=%b d=%h exp 1 0 beef", resp_valid, resp_err, resp_data);
        else pass_cnt++;
        @(negedge clk);
        for (int a = 0; a < 4; a++) begin
            cmd_we = 1'b0; cmd_bcast = 1'b0; cmd_addr = 2'(a); cmd_valid = 1'b1;
            @(negedge clk);
            cmd_valid = 1'b0;
            @(negedge clk);
            total_cnt++;
            if ({resp_valid, resp_data} !== {1'b1, 16'hBEEF})
                $display("FAIL bc_rb%0d: got rv=%b d=%h exp 1 beef", a, resp_valid, resp_data);
            else pass_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic        cw [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [1:0]  ca [4] = '{2'd0, 2'd0, 2'd3, 2'd3};
        logic [15:0] cd [4] = '{16'h1111, 16'h0, 16'h3333, 16'h0};
        int exp_acc [4] = '{0, 4, 7, 11};
        int exp_rsp [4] = '{3, 6, 10, 13};
        int acc [4] = '{-1, -1, -1, -1};
        int rsp [4] = '{-1, -1, -1, -1};
        logic [15:0] rdat [4];
        int idx = 0;
        int nresp = 0;
        int busy = 0;
        int both = 0;
        logic accepted;
        cmd_bcast = 1'b0;
        cmd_we = cw[0]; cmd_addr = ca[0]; cmd_data = cd[0]; cmd_valid = 1'b1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            accepted = cmd_valid && cmd_ready;
            if (accepted && idx < 4) acc[idx] = cyc;
            if (resp_valid) begin
                if (nresp < 4) begin
                    rsp[nresp] = cyc;
                    rdat[nresp] = resp_data;
                end
                nresp++;
            end
            if (!cmd_ready) busy++;
            if (we && rd) both++;
            @(negedge clk);
            if (accepted) begin
                idx++;
                if (idx < 4) begin
                    cmd_we = cw[idx]; cmd_addr = ca[idx]; cmd_data = cd[idx];
                end else begin
                    cmd_valid = 1'b0;
                end
            end
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (acc[i] !== exp_acc[i] || rsp[i] !== exp_rsp[i])
                $display("FAIL b2b_t%0d: got acc=%0d rsp=%0d exp acc=%0d rsp=%0d", i, acc[i], rsp[i], exp_acc[i], exp_rsp[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (nresp !== 4 || busy !== 10 || both !== 0)
            $display("FAIL b2b_cnt: got resp=%0d busy=%0d both=%0d exp 4 10 0", nresp, busy, both);
        else pass_cnt++;
        total_cnt++;
        if (rdat[1] !== 16'h1111 || rdat[3] !== 16'h3333)
            $display("FAIL b2b_data: got %h %h exp 1111 3333", rdat[1], rdat[3]);
        else pass_cnt++;
    endtask

    task automatic test_err_sat();
        int bad = 0;
        stuck2 = 1'b1;
        for (int it = 0; it < 300; it++) begin
            cmd_we = 1'b1; cmd_bcast = 1'b1; cmd_addr = 2'd0; cmd_data = 16'h00FF; cmd_valid = 1'b1;
            @(negedge clk);
            cmd_valid = 1'b0;
            repeat (8) @(negedge clk);
            if ({resp_valid, resp_err, resp_data} !== {2'b11, 16'h00FF}) bad++;
            if (it == 0) begin
                total_cnt++;
                if ({resp_valid, resp_err, resp_data, err_count} !== {2'b11, 16'h00FF, 8'd1})
                    $display("FAIL sat_first: got rv=%b re=%b d=%h err=%0d exp 1 1 00ff 1",
                             resp_valid, resp_err, resp_data, err_count);
                else pass_cnt++;
            end
            if (it == 253) begin
                total_cnt++;
                if (err_count !== 8'd254)
                    $display("FAIL sat_254: got err=%0d exp 254", err_count);
                else pass_cnt++;
            end
            @(negedge clk);
        end
        stuck2 = 1'b0;
        total_cnt++;
        if (bad !== 0 || err_count !== 8'd255)
            $display("FAIL sat_final: got bad=%0d err=%0d exp 0 255", bad, err_count);
        else pass_cnt++;
    endtask

    task automatic test_rst_mid();
        int rv = 0;
        cmd_we = 1'b1; cmd_bcast = 1'b1; cmd_addr = 2'd0; cmd_data = 16'hA5A5; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({cs, we, rd, addr} !== {3'b101, 2'd1})
            $display("FAIL rm_v1: got %b%b%b a=%h exp 101 a=1", cs, we, rd, addr);
        else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total_cnt++;
        if ({cs, we, rd, addr, wr_data, resp_valid, err_count} !== 30'h0)
            $display("FAIL rm_bus: got %b%b%b a=%h d=%h rv=%b err=%0d exp all 0",
                     cs, we, rd, addr, wr_data, resp_valid, err_count);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({cmd_ready, cs} !== 2'b10)
            $display("FAIL rm_ready: got rdy=%b cs=%b exp 1 0", cmd_ready, cs);
        else pass_cnt++;
        repeat (12) begin
            if (resp_valid || cs) rv++;
            @(negedge clk);
        end
        total_cnt++;
        if (rv !== 0 || regs[1] !== 16'hA5A5 || regs[2] !== 16'h00FF)
            $display("FAIL rm_after: got act=%0d r1=%h r2=%h exp 0 a5a5 00ff", rv, regs[1], regs[2]);
        else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_read();
        test_write();
        test_bcast();
        test_back_to_back();
        test_err_sat();
        test_rst_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
